// File: rtl/nibble_packer.sv
// Drains a show-ahead nibble FIFO, pairs consecutive nibbles into bytes and
// presents them on a valid/ready port; flush releases a lone nibble zero-padded.
module nibble_packer #(
    parameter bit          LOW_FIRST = 1'b1,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 fifo_empty,
    input  logic [3:0]           fifo_rd_data,
    output logic                 fifo_rd_en,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 out_partial,
    output logic [CNT_WIDTH-1:0] byte_count,
    output logic                 busy
);

    typedef enum logic [1:0] {
        StEmpty,
        StHalf,
        StFull
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           lo_q, lo_d;
    logic [7:0]           data_q, data_d;
    logic                 partial_q, partial_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q   <= StEmpty;
            lo_q      <= 4'h0;
            data_q    <= 8'h00;
            partial_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            data_q    <= data_d;
            partial_q <= partial_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        // In FULL a pop is only allowed when the held byte leaves this same edge.
        fifo_rd_en = rstN & ~fifo_empty & ((state_q != StFull) | out_ready);
        state_d    = state_q;
        lo_d       = lo_q;
        data_d     = data_q;
        partial_d  = partial_q;
        count_d    = count_q;

        case (state_q)
            StEmpty: begin
                if (fifo_rd_en) begin
                    lo_d    = fifo_rd_data;
                    state_d = StHalf;
                end
            end
            StHalf: begin
                if (fifo_rd_en) begin
                    data_d    = LOW_FIRST ? {fifo_rd_data, lo_q} : {lo_q, fifo_rd_data};
                    partial_d = 1'b0;
                    state_d   = StFull;
                end else if (flush) begin
                    data_d    = LOW_FIRST ? {4'h0, lo_q} : {lo_q, 4'h0};
                    partial_d = 1'b1;
                    state_d   = StFull;
                end
            end
            StFull: begin
                if (out_ready) begin
                    count_d = count_q + CNT_WIDTH'(1);
                    if (fifo_rd_en) begin
                        lo_d    = fifo_rd_data;
                        state_d = StHalf;
                    end else begin
                        state_d = StEmpty;
                    end
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    assign out_valid   = (state_q == StFull);
    assign out_data    = data_q;
    assign out_partial = partial_q;
    assign byte_count  = count_q;
    assign busy        = (state_q != StEmpty);

endmodule

// File: tb/tb_nibble_packer.sv
// Bench for nibble_packer: behavioural show-ahead FIFO in front, scoreboard
// queue of expected bytes checked by an independent handshake monitor.
module tb_nibble_packer;

    logic       clk = 1'b0;
    logic       rstN;
    logic       fifo_empty;
    logic [3:0] fifo_rd_data;
    logic       fifo_rd_en;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_partial;
    logic [7:0] byte_count;
    logic       busy;

    always #5 clk = ~clk;

    nibble_packer #(
        .LOW_FIRST(1'b1),
        .CNT_WIDTH(8)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .fifo_empty  (fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en  (fifo_rd_en),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_partial (out_partial),
        .byte_count  (byte_count),
        .busy        (busy)
    );

    // Show-ahead FIFO model; pops on the same edge fifo_rd_en is seen high.
    logic [3:0]  mem [16];
    logic [31:0] wr_ptr = 0;
    logic [31:0] rd_ptr = 0;
    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_rd_data = mem[rd_ptr[3:0]];
    always @(posedge clk) if (fifo_rd_en) rd_ptr <= rd_ptr + 1;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          exp_count = 0;
    logic [8:0]  exp_q [$];
    int          hs_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: decisions for the coming edge are stable at the falling edge.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rstN) begin
            checks++;
            if (fifo_rd_en && fifo_empty) begin
                failures++;
                $display("FAIL rd_en_while_empty: got rd_en=1 empty=1, want rd_en=0");
            end
            if (out_valid && out_ready) begin
                checks++;
                if (byte_count !== exp_count[7:0]) begin
                    failures++;
                    $display("FAIL byte_count_at_hs: got %0d, want %0d", byte_count,
                             exp_count[7:0]);
                end
                exp_count++;
                hs_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte: got data=%02h partial=%0b, want none",
                             out_data, out_partial);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_partial, out_data} !== e) begin
                        failures++;
                        $display("FAIL byte: got data=%02h partial=%0b, want data=%02h partial=%0b",
                                 out_data, out_partial, e[7:0], e[8]);
                    end
                end
            end
        end else begin
            exp_count = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_now(input logic [3:0] v);
        mem[wr_ptr[3:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic push_wait(input logic [3:0] v);
        int n = 0;
        while ((wr_ptr - rd_ptr) >= 14 && n < 100) begin
            step(1);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: got fifo level %0d, want < 14", wr_ptr - rd_ptr);
        end
        push_now(v);
        step(1);
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic p);
        exp_q.push_back({p, d});
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || !fifo_empty) && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL idle_timeout: got pending=%0d busy=%0b, want 0 0", exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [3:0] lo, hi;
        for (int i = 0; i < 16; i++) mem[i] = 4'h0;
        rstN = 1'b0;
        out_ready = 1'b1;
        flush = 1'b0;

        // Reset state, with a nibble already waiting in the FIFO
        step(2);
        push_now(4'h3);
        check("rst_rd_en", {31'b0, fifo_rd_en}, 0);
        check("rst_valid", {31'b0, out_valid}, 0);
        check("rst_data", {24'b0, out_data}, 0);
        check("rst_partial", {31'b0, out_partial}, 0);
        check("rst_count", {24'b0, byte_count}, 0);
        check("rst_busy", {31'b0, busy}, 0);

        // Basic pair
        expect_byte(8'hA3, 1'b0);
        rstN = 1'b1;
        step(1);
        push_now(4'hA);
        wait_idle(20);
        check("basic_count", {24'b0, byte_count}, 1);
        check("basic_busy", {31'b0, busy}, 0);

        // Streaming: 8 nibbles queued at once
        hs_cyc.delete();
        expect_byte(8'h21, 1'b0);
        expect_byte(8'h43, 1'b0);
        expect_byte(8'h65, 1'b0);
        expect_byte(8'h87, 1'b0);
        for (int i = 1; i <= 8; i++) push_now(4'(i));
        wait_idle(40);
        check("stream_nbytes", hs_cyc.size(), 4);
        for (int i = 1; i < hs_cyc.size(); i++)
            check("stream_gap", hs_cyc[i] - hs_cyc[i-1], 2);
        check("stream_count", {24'b0, byte_count}, 5);

        // Backpressure
        out_ready = 1'b0;
        expect_byte(8'h21, 1'b0);
        expect_byte(8'h43, 1'b0);
        expect_byte(8'h65, 1'b0);
        for (int i = 1; i <= 6; i++) push_now(4'(i));
        step(2);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'b0, out_valid}, 1);
            check("bp_data", {24'b0, out_data}, 32'h21);
            check("bp_rd_en", {31'b0, fifo_rd_en}, 0);
            step(1);
        end
        check("bp_level", wr_ptr - rd_ptr, 4);
        out_ready = 1'b1;
        wait_idle(40);
        check("bp_count", {24'b0, byte_count}, 8);

        // Flush from HALF with the FIFO empty
        push_now(4'h5);
        step(1);
        check("fl_busy_half", {31'b0, busy}, 1);
        check("fl_valid_half", {31'b0, out_valid}, 0);
        expect_byte(8'h05, 1'b1);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("fl_valid_next", {31'b0, out_valid}, 1);
        wait_idle(20);

        // Flush while EMPTY does nothing
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("fl_empty_valid", {31'b0, out_valid}, 0);
            check("fl_empty_busy", {31'b0, busy}, 0);
        end
        flush = 1'b0;

        // Reset mid-operation with 0x7 held
        push_now(4'h7);
        step(1);
        check("mid_busy", {31'b0, busy}, 1);
        rstN = 1'b0;
        step(1);
        check("mid_rst_valid", {31'b0, out_valid}, 0);
        check("mid_rst_data", {24'b0, out_data}, 0);
        check("mid_rst_partial", {31'b0, out_partial}, 0);
        check("mid_rst_count", {24'b0, byte_count}, 0);
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_rd_en", {31'b0, fifo_rd_en}, 0);
        step(1);
        rstN = 1'b1;
        expect_byte(8'h21, 1'b0);
        push_now(4'h1);
        push_now(4'h2);
        wait_idle(20);

        // Counter wrap: 255 bytes, then the 256th
        rstN = 1'b0;
        step(2);
        rstN = 1'b1;
        for (int k = 0; k < 255; k++) begin
            lo = 4'(k);
            hi = ~lo;
            expect_byte({hi, lo}, 1'b0);
            push_wait(lo);
            push_wait(hi);
        end
        wait_idle(50);
        check("wrap_255", {24'b0, byte_count}, 255);
        expect_byte(8'hC3, 1'b0);
        push_wait(4'h3);
        push_wait(4'hC);
        wait_idle(50);
        check("wrap_0", {24'b0, byte_count}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_packer.md
# nibble_packer

Downstream consumer of the 4-bit, depth-4 nibble FIFO. It drains the FIFO's show-ahead read port, pairs consecutive nibbles into bytes and presents each byte on a valid/ready output handshake. A flush request releases a lone leftover nibble as a zero-padded partial byte. Sustains one byte every two cycles, matching the FIFO's one-nibble-per-cycle rate.

## Interface
- LOW_FIRST, 1: 1 = first nibble popped goes to out_data[3:0], second to [7:4]; 0 = reversed.
- CNT_WIDTH, 8: width of byte_count.
- clk  in  1  single clock, rising edge.
- rstN  in  1  reset, synchronous, active-low.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_data  in  4  FIFO head nibble; valid whenever fifo_empty=0, combinational show-ahead.
- fifo_rd_en  out  1  pop request; FIFO advances its read pointer at the same rising edge.
- flush  in  1  level request to emit a held lone nibble as a partial byte.
- out_valid  out  1  out_data/out_partial valid.
- out_ready  in  1  consumer accepts the byte when out_valid=1 at a rising edge.
- out_data  out  8  assembled byte.
- out_partial  out  1  1 = byte came from a flush and the second nibble is padding 0x0.
- byte_count  out  CNT_WIDTH  bytes handed off since reset, counting partial bytes.
- busy  out  1  1 when state is not EMPTY.

## Operation
- States:
  - EMPTY: no nibble held.
  - HALF: one nibble held in lo_reg.
  - FULL: byte registered, out_valid=1.
- Pop condition, combinational: fifo_rd_en = rstN & ~fifo_empty & (state==EMPTY | state==HALF | (state==FULL & out_ready)).
  - Never asserted while fifo_empty=1.
  - Never asserted while in reset.
- A nibble is captured from fifo_rd_data in the same cycle fifo_rd_en=1.
- EMPTY:
  - pop -> capture into lo_reg, go to HALF.
  - No pop -> stay in EMPTY.
  - flush is ignored.
- HALF:
  - Pop -> out_data = {fifo_rd_data, lo_reg} (LOW_FIRST=1) or {lo_reg, fifo_rd_data} (LOW_FIRST=0), out_partial=0, go to FULL.
  - Otherwise flush=1 -> out_data = lo_reg placed in the first-nibble position, other nibble 0x0, out_partial=1, go to FULL.
  - Pop has priority over flush when both are possible in the same cycle.
- FULL:
  - out_data and out_partial are held stable until handshake.
  - Handshake (out_ready=1) with pop -> capture new nibble, go to HALF.
  - Handshake without pop -> go to EMPTY.
  - out_ready=0 -> stay in FULL, no pop.
- byte_count increments by 1 on each handshake and wraps from 2^CNT_WIDTH-1 to 0.
- Reset (rstN=0 at a rising edge), from any state:
  - state=EMPTY, lo_reg=0, out_valid=0, out_data=0x00, out_partial=0, byte_count=0.
  - Any held nibble or byte is discarded.
  - fifo_rd_en=0 throughout the reset cycle.

## Timing
- First nibble popped at edge n, second at edge n+1 -> out_valid=1 after edge n+1, i.e. registered output, visible in cycle n+2.
- Streaming with out_ready=1 and the FIFO never empty:
  - out_valid toggles 1,0,1,0…
  - One byte every 2 cycles.
  - fifo_rd_en stays high continuously.
- Backpressure: with out_ready held 0 in FULL, fifo_rd_en=0 and out_data is unchanged every cycle; the FIFO may fill and assert full upstream.
- Flush latency: with flush=1 and fifo_empty=1 in HALF, the partial byte is valid in the following cycle.
- out_valid never drops without a handshake, except on reset.

## Test plan
- Basic pair:
  - Stimulus: reset, write 0x3 then 0xA to the FIFO, out_ready=1.
  - Required: single pulse with out_data=0xA3, out_partial=0; byte_count=1; busy returns 0.
- Streaming:
  - Stimulus: feed nibbles 0x1..0x8 back-to-back, out_ready=1.
  - Required: bytes 0x21, 0x43, 0x65, 0x87 spaced exactly 2 cycles apart; fifo_rd_en never asserted while empty.
- Backpressure:
  - Stimulus: out_ready=0 with 6 nibbles queued.
  - Required: out_data=0x21 held stable, fifo_rd_en=0 while FULL.
  - Then release out_ready: 0x43 and 0x65 follow, no nibble lost or duplicated.
- Flush:
  - Stimulus: single nibble 0x5, FIFO empty, pulse flush.
  - Required: out_data=0x05 with out_partial=1 (LOW_FIRST=0 run: 0x50).
  - flush in EMPTY produces no output.
- Reset mid-operation:
  - Stimulus: pull rstN low while in HALF holding 0x7, then release and push 0x1, 0x2.
  - Required: first byte is 0x21 (0x7 discarded); all outputs are 0 during reset.
- Counter wrap:
  - Stimulus: 256 handshakes.
  - Required: byte_count reads 255, then 0.
